// File: rtl/bcd_sub_seq_pkg.sv
// Shared definitions for the BCD arithmetic datapath (adder and subtractor).
package bcd_sub_seq_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_sub_seq_if.sv
// Start/busy/done handshake and operand/result bus of the BCD subtractor.
interface bcd_sub_seq_if
    import bcd_sub_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    logic                      start;
    logic [BCD_W*DIGITS-1:0]   a;
    logic [BCD_W*DIGITS-1:0]   b;
    logic                      bin;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   diff;
    logic                      bout;
    logic                      err;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, err
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, err
    );
endinterface

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor: d = x - y - bi, ten's-complement on borrow.
module bcd_digit_sub
    import bcd_sub_seq_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bi,
    output logic [BCD_W-1:0] d,
    output logic             bo
);
    logic [BCD_W:0] w_t;
    logic [BCD_W:0] w_adj;

    // Signed 5-bit difference; the top bit is the sign, negative adds 10 back
    always_comb begin
        w_t   = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bi};
        w_adj = w_t + (BCD_W+1)'(10);
        if (w_t[BCD_W]) begin
            d  = w_adj[BCD_W-1:0];
            bo = 1'b1;
        end else begin
            d  = w_t[BCD_W-1:0];
            bo = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: a - b - bin, one digit per clock, LSD first.
module bcd_sub_seq
    import bcd_sub_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 4
)(
    input  logic          clk,
    input  logic          rst,
    bcd_sub_seq_if.slave  bus
);
    localparam int unsigned W     = BCD_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_work;
    logic [W-1:0]     r_diff;
    logic [IDX_W-1:0] r_idx;
    logic             r_borrow;
    logic             r_err_lat;
    logic             r_bout;
    logic             r_err;

    logic [BCD_W-1:0] w_x;
    logic [BCD_W-1:0] w_y;
    logic [BCD_W-1:0] w_d;
    logic             w_bo;
    logic             w_last;
    logic             w_start_err;
    logic [W-1:0]     w_work_next;

    bcd_digit_sub u_digit (
        .x  (w_x),
        .y  (w_y),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // Select the current digit pair and merge the new result digit into the work word
    always_comb begin
        w_x         = r_a[r_idx*BCD_W +: BCD_W];
        w_y         = r_b[r_idx*BCD_W +: BCD_W];
        w_last      = (r_idx == IDX_W'(DIGITS - 1));
        w_work_next = r_work;
        w_work_next[r_idx*BCD_W +: BCD_W] = w_d;
    end

    // Flag any non-BCD digit in the operands presented at the start edge
    always_comb begin
        w_start_err = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (digit_invalid(bus.a[k*BCD_W +: BCD_W]) ||
                digit_invalid(bus.b[k*BCD_W +: BCD_W]))
                w_start_err = 1'b1;
        end
    end

    // FSM, operand latching, digit iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_work    <= '0;
            r_diff    <= '0;
            r_idx     <= '0;
            r_borrow  <= 1'b0;
            r_err_lat <= 1'b0;
            r_bout    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_borrow  <= bus.bin;
                        r_idx     <= '0;
                        r_work    <= '0;
                        r_err_lat <= w_start_err;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_work   <= w_work_next;
                    r_borrow <= w_bo;
                    r_idx    <= w_last ? '0 : r_idx + 1'b1;
                    // Results are written on the same edge that enters DONE,
                    // so the last digit is taken from the merged word directly.
                    if (w_last) begin
                        r_diff  <= w_work_next;
                        r_bout  <= w_bo;
                        r_err   <= r_err_lat;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_bcd_sub_seq.sv
// Self-checking bench for bcd_sub_seq (DIGITS=4) and the standalone digit subtractor.
module tb_bcd_sub_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_sub_seq_if #(.DIGITS(4)) bus ();

    bcd_sub_seq #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] ds_x, ds_y, ds_d;
    logic       ds_bi, ds_bo;

    bcd_digit_sub u_ds (
        .x  (ds_x),
        .y  (ds_y),
        .bi (ds_bi),
        .d  (ds_d),
        .bo (ds_bo)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        int p = 1;
        for (int k = 0; k < 4; k++) begin
            r += int'(v[4*k +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Issue one operation from IDLE and wait (bounded) for done; returns edges to done and busy cycles
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          output int lat, output int busy_cyc);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; busy_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Step past the done cycle and confirm it was a single pulse
    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 16'(bus.done), 16'd0);
    endtask

    initial begin
        int lat, bc;
        logic [15:0] ra, rb;
        logic rbin, rerr;
        int dv;
        bit seen;

        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        ds_x = '0; ds_y = '0; ds_bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_diff", bus.diff, 16'h0000);
        check("rst_bout", 16'(bus.bout), 16'd0);
        check("rst_err",  16'(bus.err),  16'd0);
        rst = 1'b0;

        // Standalone digit subtractor, all valid digit pairs and borrow-in
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
                for (int bi = 0; bi < 2; bi++) begin
                    ds_x = 4'(x); ds_y = 4'(y); ds_bi = 1'(bi);
                    #1;
                    check("digit_d",  16'(ds_d),  16'((x - y - bi + 20) % 10));
                    check("digit_bo", 16'(ds_bo), 16'(x < y + bi));
                end

        vecs[0] = '{16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0};
        vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[4] = '{16'h00A0, 16'h0000, 1'b0, 16'h00A0, 1'b0, 1'b1};
        vecs[5] = '{16'h0009, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0};
        vecs[7] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc);
            check("vec_latency", 16'(lat + 1), 16'd5);
            check("vec_busy_cycles", 16'(bc), 16'd4);
            check("vec_diff", bus.diff, vecs[i].diff);
            check("vec_bout", 16'(bus.bout), 16'(vecs[i].bout));
            check("vec_err",  16'(bus.err),  16'(vecs[i].err));
            finish_op("vec");
        end

        // Randomized operations against the decimal reference model
        for (int n = 0; n < 40; n++) begin
            ra = '0; rb = '0;
            for (int k = 0; k < 4; k++) begin
                ra[4*k +: 4] = 4'($urandom_range(0, 9));
                rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            rbin = 1'($urandom_range(0, 1));
            rerr = 1'b0;
            for (int k = 0; k < 4; k++)
                if (ra[4*k +: 4] > 4'd9 || rb[4*k +: 4] > 4'd9) rerr = 1'b1;
            run_op(ra, rb, rbin, lat, bc);
            check("rnd_latency", 16'(lat + 1), 16'd5);
            check("rnd_err", 16'(bus.err), 16'(rerr));
            if (!rerr) begin
                dv = bcd_to_int(ra) - bcd_to_int(rb) - int'(rbin);
                check("rnd_bout", 16'(bus.bout), 16'(dv < 0));
                if (dv < 0) dv += 10000;
                check("rnd_diff", bus.diff, int_to_bcd(dv));
            end
            finish_op("rnd");
        end

        // Known previous result before the handshake sequence
        run_op(16'h0042, 16'h0017, 1'b0, lat, bc);
        check("pre_hs_diff", bus.diff, 16'h0025);
        finish_op("pre_hs");

        // start held high through RUN, operands changed mid-RUN, diff holds during RUN
        bus.a = 16'h5432; bus.b = 16'h1234; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h9999; bus.b = 16'h0000; bus.bin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hs_busy", 16'(bus.busy), 16'd1);
            check("hs_diff_hold", bus.diff, 16'h0025);
            check("hs_no_early_done", 16'(bus.done), 16'd0);
            @(posedge clk); #1;
        end
        check("hs_done", 16'(bus.done), 16'd1);
        check("hs_diff", bus.diff, 16'h4198);
        check("hs_bout", 16'(bus.bout), 16'd0);
        @(posedge clk); #1;
        check("hs_idle_done", 16'(bus.done), 16'd0);
        check("hs_idle_busy", 16'(bus.busy), 16'd0);
        @(posedge clk); #1;
        check("hs_restart_busy", 16'(bus.busy), 16'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("hs2_done_seen", 16'(seen), 16'd1);
        check("hs2_diff", bus.diff, 16'h9998);
        check("hs2_bout", 16'(bus.bout), 16'd0);
        finish_op("hs2");

        // Leave err=1 so the reset clear is visible
        run_op(16'h00A0, 16'h0000, 1'b0, lat, bc);
        check("pre_rst_err", 16'(bus.err), 16'd1);
        finish_op("pre_rst");

        // Reset in the second RUN cycle aborts without done
        bus.a = 16'h5432; bus.b = 16'h1234; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 16'(bus.busy), 16'd0);
        check("abort_done", 16'(bus.done), 16'd0);
        check("abort_diff", bus.diff, 16'h0000);
        check("abort_bout", 16'(bus.bout), 16'd0);
        check("abort_err",  16'(bus.err),  16'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("abort_stays_idle", 16'(seen), 16'd0);
        run_op(16'h0042, 16'h0017, 1'b0, lat, bc);
        check("post_rst_latency", 16'(lat + 1), 16'd5);
        check("post_rst_diff", bus.diff, 16'h0025);
        finish_op("post_rst");

        // rst and start together: reset wins
        rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", 16'(bus.busy), 16'd0);
        @(posedge clk); #1;
        check("rst_start_idle", 16'(bus.busy), 16'd0);
        check("rst_start_diff", bus.diff, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
